mc_ctrl_fsm: RTL and testbench

Parametrised multi-cycle MIPS controller: the next generation of the single-clock datapath FSM. It decodes OPCODE/FUNCT into the datapath control strobes (PC/IR/RF/DM write enables, mux selects, NPC/EXT/ALU modes) for an extended instruction set. It adds optional memory wait-state handshakes and illegal-instruction trapping. It sits between IR and the existing PC/NPC/IR/RF/EXT/ALU/DM datapath.

---
 rtl/mc_ctrl_pkg.sv | 78 +++++++
 rtl/mc_ctrl_decode.sv | 42 ++++
 rtl/mc_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs,
// state encoding, instruction classes and datapath control codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_EXE_R   = 4'd6,
    ST_EXE_I   = 4'd7,
    ST_ALU_WB  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JUMP    = 4'd10,
    ST_JAL     = 4'd11,
    ST_JR      = 4'd12,
    ST_TRAP    = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    IC_ALU_R = 4'd0,
    IC_JR    = 4'd1,
    IC_ALU_I = 4'd2,
    IC_LW    = 4'd3,
    IC_SW    = 4'd4,
    IC_BEQ   = 4'd5,
    IC_BNE   = 4'd6,
    IC_J     = 4'd7,
    IC_JAL   = 4'd8,
    IC_ILL   = 4'd9
  } iclass_t;

  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_ZERO = 4'b1001;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_UP   = 2'b10;

  localparam logic [1:0] DSEL_ALU = 2'b00;
  localparam logic [1:0] DSEL_DR  = 2'b01;
  localparam logic [1:0] DSEL_PC4 = 2'b10;

  localparam logic [1:0] RSEL_RT  = 2'b00;
  localparam logic [1:0] RSEL_RD  = 2'b01;
  localparam logic [1:0] RSEL_31  = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: op/funct to instruction class and
// the 4-bit ALU code used by EXE_R / EXE_I.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [3:0] alu_code
);

  // Classify the instruction; unknown opcodes and R-type functs are illegal
  always_comb begin
    iclass   = IC_ILL;
    alu_code = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = IC_ALU_R; alu_code = ALU_ADD; end
          FN_SUBU: begin iclass = IC_ALU_R; alu_code = ALU_SUB; end
          FN_AND:  begin iclass = IC_ALU_R; alu_code = ALU_AND; end
          FN_OR:   begin iclass = IC_ALU_R; alu_code = ALU_OR;  end
          FN_SLT:  begin iclass = IC_ALU_R; alu_code = ALU_SLT; end
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_ILL;
        endcase
      end
      OP_ORI:  begin iclass = IC_ALU_I; alu_code = ALU_OR;  end
      OP_ANDI: begin iclass = IC_ALU_I; alu_code = ALU_AND; end
      // lui: the datapath forces A to zero, so OR passes the shifted immediate
      OP_LUI:  begin iclass = IC_ALU_I; alu_code = ALU_OR;  end
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_BNE:  iclass = IC_BNE;
      OP_J:    iclass = IC_J;
      OP_JAL:  iclass = IC_JAL;
      default: iclass = IC_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS controller: Moore FSM driving datapath strobes, with
// optional memory wait states and illegal-instruction trapping.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W   = 4,
  parameter bit MEM_WAIT  = 1'b1,
  parameter bit TRAP_HALT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               b_sel,
  output logic [1:0]         d_sel,
  output logic [1:0]         r_sel,
  output logic               rf_wr,
  output logic               dm_wr,
  output logic               dm_rd,
  output logic               im_rd,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic [1:0]         npcop,
  output logic [1:0]         extop,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [3:0]         state_o
);

  state_t     state_q, state_d;
  iclass_t    iclass;
  logic [3:0] alu_code;
  logic [3:0] alu4;
  logic       imem_rdy, dmem_rdy;

  // Without wait states every access completes in its first cycle
  assign imem_rdy = MEM_WAIT ? imem_ready : 1'b1;
  assign dmem_rdy = MEM_WAIT ? dmem_ready : 1'b1;

  mc_ctrl_decode u_decode (
    .op       (op),
    .funct    (funct),
    .iclass   (iclass),
    .alu_code (alu_code)
  );

  // State register, asynchronously returned to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:   state_d = imem_rdy ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (iclass)
          IC_ALU_R: state_d = ST_EXE_R;
          IC_JR:    state_d = ST_JR;
          IC_ALU_I: state_d = ST_EXE_I;
          IC_LW,
          IC_SW:    state_d = ST_MEM_ADR;
          IC_BEQ,
          IC_BNE:   state_d = ST_BRANCH;
          IC_J:     state_d = ST_JUMP;
          IC_JAL:   state_d = ST_JAL;
          default:  state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADR: state_d = (iclass == IC_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:  state_d = dmem_rdy ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WR:  state_d = dmem_rdy ? ST_FETCH : ST_MEM_WR;
      ST_EXE_R,
      ST_EXE_I:   state_d = ST_ALU_WB;
      ST_TRAP:    state_d = TRAP_HALT ? ST_TRAP : ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Moore output decode; enables are forced low while reset is asserted
  always_comb begin
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    dm_rd   = 1'b0;
    im_rd   = 1'b0;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    npcop   = NPC_PC4;
    extop   = EXT_SIGN;
    alu4    = ALU_ADD;
    b_sel   = 1'b0;
    d_sel   = DSEL_ALU;
    r_sel   = RSEL_RT;
    illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        im_rd = 1'b1;
        pc_wr = imem_rdy;
        ir_wr = imem_rdy;
      end
      ST_MEM_ADR: begin
        b_sel = 1'b1;
        extop = EXT_SIGN;
      end
      ST_MEM_RD: dm_rd = 1'b1;
      ST_MEM_WB: begin
        rf_wr = 1'b1;
        d_sel = DSEL_DR;
        r_sel = RSEL_RT;
      end
      ST_MEM_WR: dm_wr = 1'b1;
      ST_EXE_R:  alu4 = alu_code;
      ST_EXE_I: begin
        b_sel = 1'b1;
        alu4  = alu_code;
        extop = (op == OP_LUI) ? EXT_UP : EXT_ZERO;
      end
      ST_ALU_WB: begin
        rf_wr = 1'b1;
        d_sel = DSEL_ALU;
        r_sel = (iclass == IC_ALU_R) ? RSEL_RD : RSEL_RT;
      end
      ST_BRANCH: begin
        alu4  = ALU_SUB;
        npcop = NPC_BR;
        pc_wr = (iclass == IC_BNE) ? !zero : zero;
      end
      ST_JUMP: begin
        npcop = NPC_JMP;
        pc_wr = 1'b1;
      end
      ST_JAL: begin
        npcop = NPC_JMP;
        pc_wr = 1'b1;
        rf_wr = 1'b1;
        d_sel = DSEL_PC4;
        r_sel = RSEL_31;
      end
      ST_JR: begin
        npcop = NPC_REG;
        pc_wr = 1'b1;
      end
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      rf_wr = 1'b0;
      dm_wr = 1'b0;
      dm_rd = 1'b0;
      im_rd = 1'b0;
      pc_wr = 1'b0;
      ir_wr = 1'b0;
    end
  end

  assign aluop   = ALUOP_W'(alu4);
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (MEM_WAIT = 1, TRAP_HALT = 1).
module tb_mc_ctrl_fsm;

  logic       clk, rst_n;
  logic [5:0] op, funct;
  logic       zero, imem_ready, dmem_ready;
  logic       b_sel, rf_wr, dm_wr, dm_rd, im_rd, pc_wr, ir_wr, illegal;
  logic [1:0] d_sel, r_sel, npcop, extop;
  logic [3:0] aluop, state_o;
  logic [5:0] en;

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl_fsm #(.ALUOP_W(4), .MEM_WAIT(1'b1), .TRAP_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .b_sel(b_sel), .d_sel(d_sel), .r_sel(r_sel),
    .rf_wr(rf_wr), .dm_wr(dm_wr), .dm_rd(dm_rd), .im_rd(im_rd),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .npcop(npcop), .extop(extop),
    .aluop(aluop), .illegal(illegal), .state_o(state_o)
  );

  assign en = {rf_wr, dm_wr, dm_rd, im_rd, pc_wr, ir_wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH with imem_ready high: load op/funct and advance to the first
  // execution state
  task automatic start(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    #1;
    chk("fetch_state", {28'd0, state_o}, 32'd0);
    tick();
    chk("decode_state", {28'd0, state_o}, 32'd1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {28'd0, state_o}, 32'd0);
    chk("rst_en", {26'd0, en}, 32'h00);
    #2 rst_n = 1'b1;
    #1 chk("fetch_en", {26'd0, en}, 32'h07);

    // instruction-memory wait state
    imem_ready = 1'b0;
    #1 chk("fetch_wait_en", {26'd0, en}, 32'h04);
    tick();
    chk("fetch_wait_state", {28'd0, state_o}, 32'd0);
    imem_ready = 1'b1;

    // addu
    start(6'b000000, 6'b100001);
    chk("addu_exe_state", {28'd0, state_o}, 32'd6);
    chk("addu_aluop", {28'd0, aluop}, 32'h5);
    chk("addu_bsel", {31'd0, b_sel}, 32'd0);
    chk("addu_exe_rfwr", {31'd0, rf_wr}, 32'd0);
    tick();
    chk("addu_wb_state", {28'd0, state_o}, 32'd8);
    chk("addu_wb_en", {26'd0, en}, 32'h20);
    chk("addu_rsel", {30'd0, r_sel}, 32'd1);
    chk("addu_dsel", {30'd0, d_sel}, 32'd0);
    tick();
    chk("addu_done_state", {28'd0, state_o}, 32'd0);
    chk("addu_done_rfwr", {31'd0, rf_wr}, 32'd0);

    // lw with three data wait cycles
    dmem_ready = 1'b0;
    start(6'b100011, 6'b000000);
    chk("lw_adr_state", {28'd0, state_o}, 32'd2);
    chk("lw_adr_bsel", {31'd0, b_sel}, 32'd1);
    chk("lw_adr_extop", {30'd0, extop}, 32'd1);
    chk("lw_adr_aluop", {28'd0, aluop}, 32'h5);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1'b1;
      #1;
      chk("lw_rd_state", {28'd0, state_o}, 32'd3);
      chk("lw_rd_en", {26'd0, en}, 32'h08);
      tick();
    end
    chk("lw_wb_state", {28'd0, state_o}, 32'd4);
    chk("lw_wb_en", {26'd0, en}, 32'h20);
    chk("lw_wb_dsel", {30'd0, d_sel}, 32'd1);
    chk("lw_wb_rsel", {30'd0, r_sel}, 32'd0);
    tick();
    chk("lw_done_state", {28'd0, state_o}, 32'd0);

    // beq taken
    zero = 1'b1;
    start(6'b000100, 6'b000000);
    chk("beq_state", {28'd0, state_o}, 32'd9);
    chk("beq_pcwr", {31'd0, pc_wr}, 32'd1);
    chk("beq_npcop", {30'd0, npcop}, 32'd1);
    chk("beq_aluop", {28'd0, aluop}, 32'h6);
    tick();
    chk("beq_done_state", {28'd0, state_o}, 32'd0);

    // bne with operands equal, then unequal
    start(6'b000101, 6'b000000);
    chk("bne_eq_pcwr", {31'd0, pc_wr}, 32'd0);
    zero = 1'b0;
    #1 chk("bne_ne_pcwr", {31'd0, pc_wr}, 32'd1);
    tick();

    // jal
    start(6'b000011, 6'b000000);
    chk("jal_state", {28'd0, state_o}, 32'd11);
    chk("jal_en", {26'd0, en}, 32'h22);
    chk("jal_dsel", {30'd0, d_sel}, 32'd2);
    chk("jal_rsel", {30'd0, r_sel}, 32'd2);
    chk("jal_npcop", {30'd0, npcop}, 32'd2);
    tick();
    chk("jal_done_state", {28'd0, state_o}, 32'd0);

    // jr
    start(6'b000000, 6'b001000);
    chk("jr_state", {28'd0, state_o}, 32'd12);
    chk("jr_npcop", {30'd0, npcop}, 32'd3);
    chk("jr_en", {26'd0, en}, 32'h02);
    tick();

    // ori
    start(6'b001101, 6'b000000);
    chk("ori_state", {28'd0, state_o}, 32'd7);
    chk("ori_bsel", {31'd0, b_sel}, 32'd1);
    chk("ori_extop", {30'd0, extop}, 32'd0);
    chk("ori_aluop", {28'd0, aluop}, 32'h2);
    tick();
    chk("ori_wb_en", {26'd0, en}, 32'h20);
    chk("ori_wb_rsel", {30'd0, r_sel}, 32'd0);
    tick();

    // lui
    start(6'b001111, 6'b000000);
    chk("lui_extop", {30'd0, extop}, 32'd2);
    chk("lui_aluop", {28'd0, aluop}, 32'h2);
    tick();
    tick();
    chk("lui_done_state", {28'd0, state_o}, 32'd0);

    // sw stalled, then reset dropped between clock edges
    dmem_ready = 1'b0;
    start(6'b101011, 6'b000000);
    chk("sw_adr_state", {28'd0, state_o}, 32'd2);
    tick();
    chk("sw_wr_state", {28'd0, state_o}, 32'd5);
    chk("sw_wr_en", {26'd0, en}, 32'h10);
    tick();
    chk("sw_hold_en", {26'd0, en}, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("sw_rst_dmwr", {31'd0, dm_wr}, 32'd0);
    chk("sw_rst_state", {28'd0, state_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    #1;
    chk("sw_rel_state", {28'd0, state_o}, 32'd0);
    chk("sw_rel_en", {26'd0, en}, 32'h07);

    // unknown R-type funct traps and parks
    start(6'b000000, 6'b000000);
    chk("badfn_state", {28'd0, state_o}, 32'd13);
    chk("badfn_illegal", {31'd0, illegal}, 32'd1);
    rst_n = 1'b0;
    #1 chk("badfn_rst_state", {28'd0, state_o}, 32'd0);
    tick();
    rst_n = 1'b1;

    // illegal opcode with TRAP_HALT: parked for 20 cycles
    start(6'b111111, 6'b000000);
    chk("trap_state", {28'd0, state_o}, 32'd13);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("trap_hold_illegal", {31'd0, illegal}, 32'd1);
      chk("trap_hold_en", {26'd0, en}, 32'h00);
    end
    rst_n = 1'b0;
    #1;
    chk("trap_rst_state", {28'd0, state_o}, 32'd0);
    chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("trap_rel_en", {26'd0, en}, 32'h07);
    tick();
    chk("trap_rel_decode", {28'd0, state_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
